seq_decode_execute: RTL and testbench

Registered, parametrised successor of the 4-bit combinational decode-and-execute unit. Accepts one `op_code`/`rs`/`rt` instruction through a valid/ready handshake and executes the eight-operation set: single-cycle ALU ops, or an iterative shift-add multiply. It returns `rd` plus a status flag through a second valid/ready handshake. It sits between the instruction sequencer and the register write-back stage, and output backpressure stalls intake.

---
 rtl/decode_execute_pkg.sv | 19 +
 rtl/shift_add_multiplier.sv | 60 ++++++
 rtl/seq_decode_execute.sv | 147 ++++++++++++++
 tb/tb_seq_decode_execute.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/decode_execute_pkg.sv
// rtl/decode_execute_pkg.sv - opcode constants and FSM state encoding for seq_decode_execute
package decode_execute_pkg;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_INC  = 3'b010;
  localparam logic [2:0] OP_NOR  = 3'b011;
  localparam logic [2:0] OP_NAND = 3'b100;
  localparam logic [2:0] OP_SHR2 = 3'b101;
  localparam logic [2:0] OP_SHL1 = 3'b110;
  localparam logic [2:0] OP_MUL  = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

endpackage

// File: rtl/shift_add_multiplier.sv
// rtl/shift_add_multiplier.sv - iterative shift-add multiplier, one partial product per cycle
module shift_add_multiplier #(
  parameter int WIDTH = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_product,
  output logic             o_ovf
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  logic [2*WIDTH-1:0] r_acc;
  logic [2*WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0]   r_mplier;
  logic [CW-1:0]      r_cnt;
  logic               r_busy;

  logic [2*WIDTH-1:0] w_acc_next;
  logic               w_last;

  assign w_acc_next = r_acc + (r_mplier[0] ? r_mcand : '0);
  assign w_last     = (r_cnt == CW'(WIDTH - 1));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_cnt    <= '0;
      r_busy   <= 1'b0;
    end else if (i_start) begin
      r_acc    <= '0;
      r_mcand  <= {{WIDTH{1'b0}}, i_a};
      r_mplier <= i_b;
      r_cnt    <= '0;
      r_busy   <= 1'b1;
    end else if (r_busy) begin
      r_acc    <= w_acc_next;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_cnt    <= r_cnt + CW'(1);
      if (w_last) begin
        r_busy <= 1'b0;
      end
    end
  end

  // Result is taken from the final iteration's sum so the caller can register it on the same edge.
  assign o_busy    = r_busy;
  assign o_done    = r_busy & w_last;
  assign o_product = w_acc_next[WIDTH-1:0];
  assign o_ovf     = |w_acc_next[2*WIDTH-1:WIDTH];

endmodule

// File: rtl/seq_decode_execute.sv
// rtl/seq_decode_execute.sv - registered decode/execute unit with valid/ready handshakes and iterative MUL
module seq_decode_execute
  import decode_execute_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_in_valid,
  output logic             o_in_ready,
  input  logic [2:0]       i_op_code,
  input  logic [WIDTH-1:0] i_rs,
  input  logic [WIDTH-1:0] i_rt,
  output logic             o_out_valid,
  input  logic             i_out_ready,
  output logic [WIDTH-1:0] o_rd,
  output logic             o_flag
);

  state_t r_state;
  state_t w_next;

  logic             r_out_valid;
  logic [WIDTH-1:0] r_rd;
  logic             r_flag;

  logic             w_accept;
  logic             w_is_mul;
  logic             w_mul_start;
  logic             w_mul_busy;
  logic             w_mul_done;
  logic [WIDTH-1:0] w_mul_product;
  logic             w_mul_ovf;
  logic             w_mul_complete;

  logic [WIDTH-1:0] w_alu_rd;
  logic             w_alu_flag;
  logic [WIDTH:0]   w_sum;

  // Single-cycle operations; MUL is handled by the iterative multiplier.
  always_comb begin
    w_alu_rd   = '0;
    w_alu_flag = 1'b0;
    w_sum      = '0;
    case (i_op_code)
      OP_ADD: begin
        w_sum      = {1'b0, i_rs} + {1'b0, i_rt};
        w_alu_rd   = w_sum[WIDTH-1:0];
        w_alu_flag = w_sum[WIDTH];
      end
      OP_SUB: begin
        w_alu_rd   = i_rs - i_rt;
        w_alu_flag = (i_rs >= i_rt);
      end
      OP_INC: begin
        w_sum      = {1'b0, i_rs} + {{WIDTH{1'b0}}, 1'b1};
        w_alu_rd   = w_sum[WIDTH-1:0];
        w_alu_flag = w_sum[WIDTH];
      end
      OP_NOR:  w_alu_rd = ~(i_rs | i_rt);
      OP_NAND: w_alu_rd = ~(i_rs & i_rt);
      OP_SHR2: w_alu_rd = i_rs >> 2;
      OP_SHL1: w_alu_rd = i_rs << 1;
      default: begin
        w_alu_rd   = '0;
        w_alu_flag = 1'b0;
      end
    endcase
  end

  assign w_is_mul       = (i_op_code == OP_MUL);
  assign w_accept       = i_in_valid & o_in_ready;
  assign w_mul_start    = w_accept & w_is_mul;
  assign w_mul_complete = (r_state == ST_MUL) & w_mul_done;

  // in_ready depends only on state and out_ready, never on in_valid.
  always_comb begin
    w_next     = r_state;
    o_in_ready = 1'b0;
    case (r_state)
      ST_IDLE: begin
        o_in_ready = 1'b1;
        if (i_in_valid) begin
          w_next = w_is_mul ? ST_MUL : ST_HOLD;
        end
      end
      ST_MUL: begin
        if (w_mul_done) begin
          w_next = ST_HOLD;
        end else if (!w_mul_busy) begin
          w_next = ST_IDLE;
        end
      end
      ST_HOLD: begin
        o_in_ready = i_out_ready;
        if (i_out_ready) begin
          if (i_in_valid) begin
            w_next = w_is_mul ? ST_MUL : ST_HOLD;
          end else begin
            w_next = ST_IDLE;
          end
        end
      end
      default: begin
        w_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= ST_IDLE;
      r_out_valid <= 1'b0;
      r_rd        <= '0;
      r_flag      <= 1'b0;
    end else begin
      r_state     <= w_next;
      r_out_valid <= (w_next == ST_HOLD);
      if (w_accept && !w_is_mul) begin
        r_rd   <= w_alu_rd;
        r_flag <= w_alu_flag;
      end else if (w_mul_complete) begin
        r_rd   <= w_mul_product;
        r_flag <= w_mul_ovf;
      end
    end
  end

  shift_add_multiplier #(
    .WIDTH(WIDTH)
  ) u_mul (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_start  (w_mul_start),
    .i_a      (i_rs),
    .i_b      (i_rt),
    .o_busy   (w_mul_busy),
    .o_done   (w_mul_done),
    .o_product(w_mul_product),
    .o_ovf    (w_mul_ovf)
  );

  assign o_out_valid = r_out_valid;
  assign o_rd        = r_rd;
  assign o_flag      = r_flag;

endmodule

// File: tb/tb_seq_decode_execute.sv
// tb/tb_seq_decode_execute.sv - self-checking bench for seq_decode_execute at WIDTH 4 and 8
module tb_seq_decode_execute;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       a_in_valid = 1'b0, a_in_ready, a_out_valid, a_out_ready = 1'b0, a_flag;
  logic [2:0] a_op = 3'd0;
  logic [3:0] a_rs = 4'd0, a_rt = 4'd0, a_rd;

  logic       b_in_valid = 1'b0, b_in_ready, b_out_valid, b_out_ready = 1'b0, b_flag;
  logic [2:0] b_op = 3'd0;
  logic [7:0] b_rs = 8'd0, b_rt = 8'd0, b_rd;

  int vectors = 0;
  int miscompares = 0;

  seq_decode_execute #(.WIDTH(4)) dut4 (
    .i_clk(clk), .i_rst_n(rst_n), .i_in_valid(a_in_valid), .o_in_ready(a_in_ready),
    .i_op_code(a_op), .i_rs(a_rs), .i_rt(a_rt), .o_out_valid(a_out_valid),
    .i_out_ready(a_out_ready), .o_rd(a_rd), .o_flag(a_flag)
  );

  seq_decode_execute #(.WIDTH(8)) dut8 (
    .i_clk(clk), .i_rst_n(rst_n), .i_in_valid(b_in_valid), .o_in_ready(b_in_ready),
    .i_op_code(b_op), .i_rs(b_rs), .i_rt(b_rt), .o_out_valid(b_out_valid),
    .i_out_ready(b_out_ready), .o_rd(b_rd), .o_flag(b_flag)
  );

  // Reference: arithmetic on unbounded integers, then reduced mod 2^w.
  function automatic void ref_op(input int w, input int op, input int rs, input int rt,
                                 output int rd, output int fl);
    int m;
    int s;
    m  = 1 << w;
    fl = 0;
    case (op)
      0: begin s = rs + rt; rd = s % m; fl = (s >= m) ? 1 : 0; end
      1: begin rd = (rs - rt + m) % m; fl = (rs >= rt) ? 1 : 0; end
      2: begin s = rs + 1; rd = s % m; fl = (s >= m) ? 1 : 0; end
      3: rd = ~(rs | rt) & (m - 1);
      4: rd = ~(rs & rt) & (m - 1);
      5: rd = rs / 4;
      6: rd = (rs * 2) % m;
      default: begin s = rs * rt; rd = s % m; fl = (s >= m) ? 1 : 0; end
    endcase
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    vectors++;
    if (a_out_valid !== 1'b0 || a_rd !== 4'd0 || a_flag !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_w4: valid=%b rd=%0h flag=%b expected 0/0/0", a_out_valid, a_rd, a_flag);
    end
    vectors++;
    if (b_out_valid !== 1'b0 || b_rd !== 8'd0 || b_flag !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_w8: valid=%b rd=%0h flag=%b expected 0/0/0", b_out_valid, b_rd, b_flag);
    end
    rst_n = 1'b1;
    a_out_ready = 1'b1;
    b_out_ready = 1'b1;
    #1;
    vectors++;
    if (a_in_ready !== 1'b1 || b_in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_in_ready: got %b/%b expected 1/1", a_in_ready, b_in_ready);
    end
  endtask

  task automatic test_reset_mid_mul();
    @(negedge clk);
    a_in_valid = 1'b1; a_op = 3'd7; a_rs = 4'd9; a_rt = 4'd9;
    @(posedge clk);
    @(negedge clk);
    a_in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    vectors++;
    if (a_out_valid !== 1'b0 || a_rd !== 4'd0) begin
      miscompares++;
      $display("FAIL midmul_reset: valid=%b rd=%0h expected 0/0", a_out_valid, a_rd);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    vectors++;
    if (a_out_valid !== 1'b0 || a_rd !== 4'd0 || a_flag !== 1'b0) begin
      miscompares++;
      $display("FAIL midmul_aborted: valid=%b rd=%0h flag=%b expected 0/0/0", a_out_valid, a_rd, a_flag);
    end
    a_in_valid = 1'b1; a_op = 3'd0; a_rs = 4'd1; a_rt = 4'd1;
    @(posedge clk);
    @(negedge clk);
    a_in_valid = 1'b0;
    vectors++;
    if (a_out_valid !== 1'b1 || a_rd !== 4'd2 || a_flag !== 1'b0) begin
      miscompares++;
      $display("FAIL midmul_add_after: valid=%b rd=%0h flag=%b expected 1/2/0", a_out_valid, a_rd, a_flag);
    end
    @(posedge clk);
  endtask

  task automatic test_back_to_back();
    logic [2:0] t_op [7] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6};
    logic [3:0] t_rs [7] = '{4'h7, 4'h3, 4'hF, 4'hA, 4'hC, 4'hB, 4'hB};
    logic [3:0] t_rt [7] = '{4'h9, 4'h5, 4'h0, 4'h5, 4'hA, 4'h0, 4'h0};
    logic [3:0] t_rd [7] = '{4'h0, 4'hE, 4'h0, 4'h0, 4'h7, 4'h2, 4'h6};
    logic       t_fl [7] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    a_out_ready = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 7; i++) begin
      a_in_valid = 1'b1; a_op = t_op[i]; a_rs = t_rs[i]; a_rt = t_rt[i];
      #1;
      vectors++;
      if (a_in_ready !== 1'b1) begin
        miscompares++;
        $display("FAIL b2b_in_ready[%0d]: got %b expected 1", i, a_in_ready);
      end
      @(posedge clk);
      @(negedge clk);
      vectors++;
      if (a_out_valid !== 1'b1 || a_rd !== t_rd[i] || a_flag !== t_fl[i]) begin
        miscompares++;
        $display("FAIL b2b_result[%0d]: valid=%b rd=%0h flag=%b expected 1/%0h/%b",
                 i, a_out_valid, a_rd, a_flag, t_rd[i], t_fl[i]);
      end
    end
    a_in_valid = 1'b0;
    @(posedge clk);
  endtask

  task automatic do_mul4(input logic [3:0] rs, input logic [3:0] rt,
                         input logic [3:0] exp_rd, input logic exp_fl);
    @(negedge clk);
    a_in_valid = 1'b1; a_op = 3'd7; a_rs = rs; a_rt = rt;
    @(posedge clk);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      a_in_valid = 1'b0;
      a_rs = ~rs; a_rt = ~rt;
      vectors++;
      if (a_out_valid !== 1'b0 || a_in_ready !== 1'b0) begin
        miscompares++;
        $display("FAIL mul_busy_%0dx%0d[%0d]: valid=%b in_ready=%b expected 0/0", rs, rt, k, a_out_valid, a_in_ready);
      end
      @(posedge clk);
    end
    @(negedge clk);
    vectors++;
    if (a_out_valid !== 1'b1 || a_rd !== exp_rd || a_flag !== exp_fl) begin
      miscompares++;
      $display("FAIL mul_result_%0dx%0d: valid=%b rd=%0h flag=%b expected 1/%0h/%b",
               rs, rt, a_out_valid, a_rd, a_flag, exp_rd, exp_fl);
    end
  endtask

  task automatic test_mul();
    a_out_ready = 1'b1;
    do_mul4(4'd5, 4'd3, 4'd15, 1'b0);
    do_mul4(4'd7, 4'd6, 4'hA, 1'b1);
    @(posedge clk);
  endtask

  task automatic test_backpressure();
    @(negedge clk);
    a_out_ready = 1'b0;
    a_in_valid = 1'b1; a_op = 3'd0; a_rs = 4'd2; a_rt = 4'd3;
    @(posedge clk);
    @(negedge clk);
    a_op = 3'd1; a_rs = 4'd9; a_rt = 4'd2;
    for (int k = 0; k < 3; k++) begin
      vectors++;
      if (a_out_valid !== 1'b1 || a_rd !== 4'd5 || a_flag !== 1'b0 || a_in_ready !== 1'b0) begin
        miscompares++;
        $display("FAIL bp_hold[%0d]: valid=%b rd=%0h flag=%b in_ready=%b expected 1/5/0/0",
                 k, a_out_valid, a_rd, a_flag, a_in_ready);
      end
      @(posedge clk);
      @(negedge clk);
    end
    a_out_ready = 1'b1;
    #1;
    vectors++;
    if (a_in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL bp_release_ready: got %b expected 1", a_in_ready);
    end
    @(posedge clk);
    @(negedge clk);
    a_in_valid = 1'b0;
    vectors++;
    if (a_out_valid !== 1'b1 || a_rd !== 4'd7 || a_flag !== 1'b1) begin
      miscompares++;
      $display("FAIL bp_sub_taken: valid=%b rd=%0h flag=%b expected 1/7/1", a_out_valid, a_rd, a_flag);
    end
    @(posedge clk);
    @(negedge clk);
    vectors++;
    if (a_out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL bp_drain: valid=%b expected 0", a_out_valid);
    end
  endtask

  task automatic test_width8();
    @(negedge clk);
    b_out_ready = 1'b1;
    b_in_valid = 1'b1; b_op = 3'd7; b_rs = 8'd200; b_rt = 8'd2;
    @(posedge clk);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      b_in_valid = 1'b0;
      vectors++;
      if (b_out_valid !== 1'b0 || b_in_ready !== 1'b0) begin
        miscompares++;
        $display("FAIL w8_mul_busy[%0d]: valid=%b in_ready=%b expected 0/0", k, b_out_valid, b_in_ready);
      end
      @(posedge clk);
    end
    @(negedge clk);
    vectors++;
    if (b_out_valid !== 1'b1 || b_rd !== 8'd144 || b_flag !== 1'b1) begin
      miscompares++;
      $display("FAIL w8_mul: valid=%b rd=%0d flag=%b expected 1/144/1", b_out_valid, b_rd, b_flag);
    end
    b_in_valid = 1'b1; b_op = 3'd1; b_rs = 8'd10; b_rt = 8'd10;
    @(posedge clk);
    @(negedge clk);
    b_in_valid = 1'b0;
    vectors++;
    if (b_out_valid !== 1'b1 || b_rd !== 8'd0 || b_flag !== 1'b1) begin
      miscompares++;
      $display("FAIL w8_sub_equal: valid=%b rd=%0d flag=%b expected 1/0/1", b_out_valid, b_rd, b_flag);
    end
    @(posedge clk);
  endtask

  task automatic test_random();
    int q_rd[$];
    int q_fl[$];
    int erd;
    int efl;
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(negedge clk);
      if (a_out_valid) begin
        vectors++;
        if (q_rd.size() == 0) begin
          miscompares++;
          $display("FAIL rand_spurious[%0d]: out_valid=1 with no result outstanding", cyc);
        end else if (a_rd !== q_rd[0][3:0] || a_flag !== q_fl[0][0]) begin
          miscompares++;
          $display("FAIL rand_result[%0d]: rd=%0h flag=%b expected %0h/%0d", cyc, a_rd, a_flag, q_rd[0], q_fl[0]);
        end
      end
      a_in_valid  = ($urandom_range(0, 3) != 0);
      a_out_ready = ($urandom_range(0, 3) != 0);
      a_op = 3'($urandom_range(0, 7));
      a_rs = 4'($urandom_range(0, 15));
      a_rt = 4'($urandom_range(0, 15));
      #1;
      if (a_out_valid && a_out_ready && q_rd.size() != 0) begin
        void'(q_rd.pop_front());
        void'(q_fl.pop_front());
      end
      if (a_in_valid && a_in_ready) begin
        ref_op(4, int'(a_op), int'(a_rs), int'(a_rt), erd, efl);
        q_rd.push_back(erd);
        q_fl.push_back(efl);
      end
    end
    @(negedge clk);
    a_in_valid = 1'b0;
    a_out_ready = 1'b1;
    for (int cyc = 0; cyc < 12; cyc++) begin
      @(negedge clk);
      if (a_out_valid && q_rd.size() != 0) begin
        vectors++;
        if (a_rd !== q_rd[0][3:0] || a_flag !== q_fl[0][0]) begin
          miscompares++;
          $display("FAIL rand_drain: rd=%0h flag=%b expected %0h/%0d", a_rd, a_flag, q_rd[0], q_fl[0]);
        end
        void'(q_rd.pop_front());
        void'(q_fl.pop_front());
      end
    end
    vectors++;
    if (q_rd.size() != 0 || a_out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL rand_outstanding: %0d results never delivered, out_valid=%b", q_rd.size(), a_out_valid);
    end
  endtask

  initial begin
    test_reset();
    test_reset_mid_mul();
    test_back_to_back();
    test_mul();
    test_backpressure();
    test_width8();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
